// File: rtl/demux_dest_pkg.sv
// Shared definitions for the demux_dest block: FSM encoding, default word width
// and the push-counter width used when DEMUX_DEST_COUNT_EN is defined.
package demux_dest_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      ROUTE = 2'd2
   } demux_state_e;

   localparam int DATA_SIZE_DEF = 6;
   localparam int CNT_W         = 8;

endpackage

// File: rtl/demux_dest_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter
   import demux_dest_pkg::*;
#(
   parameter int WIDTH = CNT_W
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/demux_dest.sv
// Pops words from a source FIFO and pushes each to d0 or d1 selected by data bit DEST_BIT.
// Optional per-destination push counters are built when DEMUX_DEST_COUNT_EN is defined.
module demux_dest
   import demux_dest_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int DEST_BIT  = 4
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic                 fifo_empty_in,
   input  logic [DATA_SIZE-1:0] data_in,
   output logic                 pop_in,
   input  logic                 fifo_pause_d0,
   input  logic                 fifo_pause_d1,
   output logic                 push_d0,
   output logic                 push_d1,
   output logic [DATA_SIZE-1:0] data_d0,
   output logic [DATA_SIZE-1:0] data_d1,
   output logic                 demux_error,
   output logic [1:0]           state_dbg
`ifdef DEMUX_DEST_COUNT_EN
   ,
   output logic [CNT_W-1:0]     count_d0,
   output logic [CNT_W-1:0]     count_d1
`endif
);

   demux_state_e         state_q, state_d;
   logic [DATA_SIZE-1:0] hold_q, hold_d;
   logic                 error_q, error_d;
   logic                 pop, push0, push1;
   logic                 sel, clear;

   // Handshake: pop_in is a one-cycle strobe, data_in is valid the cycle after it.
   // push_dX is a one-cycle strobe; data_dX is qualified only by it.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      pop     = 1'b0;
      push0   = 1'b0;
      push1   = 1'b0;
      sel     = hold_q[DEST_BIT];
      clear   = sel ? !fifo_pause_d1 : !fifo_pause_d0;
      case (state_q)
         IDLE: begin
            pop = !fifo_empty_in;
            if (pop) state_d = WAIT;
         end
         WAIT: begin
            hold_d  = data_in;
            state_d = ROUTE;
         end
         ROUTE: begin
            if (clear) begin
               push0 = !sel;
               push1 = sel;
               if (!fifo_empty_in) begin
                  pop     = 1'b1;
                  state_d = WAIT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Strobes are forced low during reset so an in-flight word is dropped.
      if (!reset_L) begin
         pop   = 1'b0;
         push0 = 1'b0;
         push1 = 1'b0;
      end
      error_d = error_q | (pop & fifo_empty_in);
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state_q <= IDLE;
         hold_q  <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         error_q <= error_d;
      end
   end

   assign pop_in      = pop;
   assign push_d0     = push0;
   assign push_d1     = push1;
   assign data_d0     = reset_L ? hold_q : '0;
   assign data_d1     = reset_L ? hold_q : '0;
   assign demux_error = error_q;
   assign state_dbg   = state_q;

`ifdef DEMUX_DEST_COUNT_EN
   sat_counter #(.WIDTH(CNT_W)) u_cnt_d0 (
      .clk     (clk),
      .reset_L (reset_L),
      .inc     (push0),
      .count   (count_d0)
   );

   sat_counter #(.WIDTH(CNT_W)) u_cnt_d1 (
      .clk     (clk),
      .reset_L (reset_L),
      .inc     (push1),
      .count   (count_d1)
   );
`endif

endmodule

// File: doc/demux_dest.md
DEMUX_DEST -- requirements
Module: demux_dest

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 6, giving the word width in bits.
REQ-002 SHALL have parameter DEST_BIT, default 4, giving the bit index of data_in that selects the destination (0 = d0, 1 = d1).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-004 SHALL have port reset_L, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port fifo_empty_in, input, 1, source FIFO empty flag.
REQ-006 SHALL have port data_in, input, DATA_SIZE, source FIFO registered pop data, valid the cycle after pop_in.
REQ-007 SHALL have port pop_in, output, 1, pop strobe to the source FIFO.
REQ-008 SHALL have ports fifo_pause_d0 and fifo_pause_d1, input, 1 each, almost-full back-pressure from the destination FIFOs.
REQ-009 SHALL have ports push_d0 and push_d1, output, 1 each, push strobes to the destination FIFOs.
REQ-010 SHALL have ports data_d0 and data_d1, output, DATA_SIZE each, push data to the destination FIFOs.
REQ-011 SHALL have port demux_error, output, 1, sticky protocol-error flag.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, WAIT, ROUTE.
REQ-013 IDLE: pop_in = !fifo_empty_in (combinational); if pop_in, next state SHALL be WAIT, else stay in IDLE.
REQ-014 WAIT: pop_in = 0; SHALL capture data_in into a hold register; next state SHALL be ROUTE.
REQ-015 ROUTE: sel = hold[DEST_BIT]; the selected destination is "clear" when its pause input is 0.
REQ-016 ROUTE, selected destination clear: SHALL assert push_dsel = 1 combinationally for that cycle; the unselected push SHALL be 0.
REQ-017 ROUTE, selected destination paused: push SHALL be 0 and the FSM SHALL hold ROUTE with the hold register unchanged; pause of the unselected destination SHALL have no effect.
REQ-018 ROUTE with push asserted and !fifo_empty_in: SHALL assert pop_in in the same cycle and go to WAIT (back-to-back).
REQ-019 ROUTE with push asserted and fifo_empty_in: SHALL go to IDLE.
REQ-020 Throughput SHALL be one word per 2 cycles sustained; latency from pop_in to push SHALL be 2 cycles when unpaused.
REQ-021 data_d0 and data_d1 SHALL both carry the hold register at all times; only the push strobes qualify the data.
REQ-022 push_d0 and push_d1 SHALL never both be 1.
REQ-023 SHALL set demux_error, sticky until reset, if pop_in is asserted while fifo_empty_in = 1; this is unreachable by design and serves as a checker.

Reset
REQ-024 With reset_L = 0 at posedge: state = IDLE, hold = 0, demux_error = 0, counters = 0.
REQ-025 While reset_L = 0: pop_in = 0, push_d0 = 0, push_d1 = 0, data_d0 = 0, data_d1 = 0.
REQ-026 Reset asserted in WAIT or ROUTE SHALL discard the held or in-flight word without pushing it.

Configuration
REQ-027 Macro DEMUX_DEST_COUNT_EN defined: SHALL add 8-bit outputs count_d0 and count_d1, each incremented on its push and saturating at 255, both reset to 0.
REQ-028 Macro DEMUX_DEST_COUNT_EN undefined: the count ports and counter logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE = 2'd0, WAIT = 2'd1, ROUTE = 2'd2), the DATA_SIZE default and the counter width constant 8.
REQ-030 The saturating counter SHALL be one sub-module, sat_counter, instantiated twice and only when DEMUX_DEST_COUNT_EN is defined.

Verification
REQ-031 Reset with fifo_empty_in = 0 -> pop_in = 0 and no push during reset; first pop_in appears in the cycle after reset_L rises.
REQ-032 Source holds 6'h10 then 6'h05, no pause -> push_d1 with data_d1 = 6'h10 two cycles after its pop, then push_d0 with data_d0 = 6'h05 two cycles later.
REQ-033 Word 6'h13 held with fifo_pause_d1 = 1 for 4 cycles -> no push for 4 cycles, hold unchanged; push_d1 fires in the cycle pause drops.
REQ-034 Word 6'h03 (to d0) with fifo_pause_d1 = 1 -> push_d0 fires with no stall.
REQ-035 Reset pulsed while in ROUTE with word 6'h1F held -> no push occurs and FSM returns to IDLE.
REQ-036 With DEMUX_DEST_COUNT_EN defined, 300 words to d0 -> count_d0 = 255 and count_d1 = 0.
